uart_rx: RTL and testbench

Oversampling UART receiver sitting directly downstream of the UART clock divider. It consumes the divider's `uart_clk` output, which runs at 4 samples per bit, as a sample-rate reference inside the system clock domain. It deserialises 8N1-style frames from the `rx` pin and presents each received word with a one-cycle valid strobe, or flags a framing error.

---
 rtl/uart_rx.sv | 126 ++++++++++++
 tb/tb_uart_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 4 sample ticks per bit, derived from the rising edges of uart_clk.
// Each bit is sampled 2 ticks after start detection; each good frame yields a one-cycle valid pulse.
module uart_rx #(
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 res,
   input  logic                 uart_clk,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int IW = $clog2(DATA_BITS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t               state, state_n;
   logic                 uc_q;
   logic                 rx_p0, rx_s;
   logic [1:0]           sc, sc_n;
   logic [IW-1:0]        bit_idx, bit_idx_n;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic [DATA_BITS-1:0] data_n;
   logic                 valid_n, frame_err_n;
   logic                 tick;

   assign tick = uart_clk & ~uc_q;
   assign busy = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (res) begin
         state     <= S_IDLE;
         uc_q      <= 1'b0;
         rx_p0     <= 1'b1;
         rx_s      <= 1'b1;
         sc        <= 2'd0;
         bit_idx   <= '0;
         shreg     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         uc_q      <= uart_clk;
         rx_p0     <= rx;
         rx_s      <= rx_p0;
         sc        <= sc_n;
         bit_idx   <= bit_idx_n;
         shreg     <= shreg_n;
         data      <= data_n;
         valid     <= valid_n;
         frame_err <= frame_err_n;
      end
   end

   always_comb begin
      state_n     = state;
      sc_n        = sc;
      bit_idx_n   = bit_idx;
      shreg_n     = shreg;
      data_n      = data;
      valid_n     = 1'b0;
      frame_err_n = 1'b0;

      if (tick && state != S_IDLE)
         sc_n = sc + 2'd1;

      case (state)
         S_IDLE: begin
            if (tick && !rx_s) begin
               state_n   = S_START;
               sc_n      = 2'd1;
               bit_idx_n = '0;
            end
         end
         S_START: begin
            // A start bit that is high again at mid-bit was only a glitch
            if (tick && sc == 2'd2 && rx_s)
               state_n = S_IDLE;
            else if (tick && sc == 2'd3)
               state_n = S_DATA;
         end
         S_DATA: begin
            if (tick && sc == 2'd2) begin
               for (int i = 0; i < DATA_BITS; i++)
                  if (bit_idx == IW'(i))
                     shreg_n[i] = rx_s;
            end
            if (tick && sc == 2'd3) begin
               if (bit_idx == IW'(DATA_BITS - 1))
                  state_n = S_STOP;
               else
                  bit_idx_n = bit_idx + IW'(1);
            end
         end
         S_STOP: begin
            // Leaving mid-stop-bit lets a directly following start edge be caught
            if (tick && sc == 2'd2) begin
               if (rx_s) begin
                  data_n  = shreg;
                  valid_n = 1'b1;
                  state_n = S_IDLE;
               end else begin
                  frame_err_n = 1'b1;
                  state_n     = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            if (rx_s)
               state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: frames are described as (byte, stop bit) and the expected
// valid / framing-error events are derived from that description, then compared to observed pulses.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       res;
   logic       uart_clk;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   uart_rx #(.DATA_BITS(8)) dut (
      .clk       (clk),
      .res       (res),
      .uart_clk  (uart_clk),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int         n_chk  = 0;
   int         n_pass = 0;
   logic       uc_run = 1'b1;
   logic [7:0] last_good = 8'h00;
   logic [31:0] got_q[$];
   logic [31:0] exp_q[$];
   logic       pv = 1'b0, pb = 1'b0, pf = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // Sample-rate reference: one uart_clk rising edge every 6 clk
   initial begin
      uart_clk = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         if (uc_run) uart_clk = ~uart_clk;
         else        uart_clk = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (valid || frame_err) begin
         check("excl", 32'(valid & frame_err), 32'd0);
         got_q.push_back(valid ? (32'h100 | 32'(data)) : (32'h200 | 32'(data)));
      end
      if (valid) begin
         check("valid_width", 32'(pv), 32'd0);
         check("busy_fall", 32'({pb, busy}), 32'd2);
      end
      if (frame_err) check("ferr_width", 32'(pf), 32'd0);
      pv <= valid;
      pb <= busy;
      pf <= frame_err;
   end

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (24) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop);
      if (stop) begin
         exp_q.push_back(32'h100 | 32'(d));
         last_good = d;
      end else begin
         exp_q.push_back(32'h200 | 32'(last_good));
      end
   endtask

   task automatic compare_events(input string tag);
      int n;
      n = 0;
      while (busy && n < 600) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_idle"}, 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check({tag, "_event"}, got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int busy_cnt;
      logic [7:0] d;
      logic       stop;

      res = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_data", 32'(data), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_ferr", 32'(frame_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      res = 1'b0;
      repeat (30) @(negedge clk);

      // Single good frame
      send_frame(8'hA5, 1'b1);
      compare_events("a5");
      check("a5_data", 32'(data), 32'hA5);

      // Framing error, held break, then recovery
      send_frame(8'h00, 1'b0);
      repeat (100) @(negedge clk);
      check("break_busy", 32'(busy), 32'd1);
      check("break_data", 32'(data), 32'hA5);
      rx = 1'b1;
      repeat (4) @(negedge clk);
      check("break_release", 32'(busy), 32'd0);
      repeat (24) @(negedge clk);
      send_frame(8'h3C, 1'b1);
      compare_events("ferr");

      // Short low glitch on an idle line
      repeat (24) @(negedge clk);
      rx = 1'b0;
      busy_cnt = 0;
      for (int i = 0; i < 80; i++) begin
         if (i == 6) rx = 1'b1;
         @(negedge clk);
         if (busy) busy_cnt++;
      end
      check("glitch_busy_le18", 32'(busy_cnt <= 18), 32'd1);
      compare_events("glitch");

      // Back-to-back frames, no idle gap
      send_frame(8'h01, 1'b1);
      send_frame(8'hFE, 1'b1);
      compare_events("b2b");

      // Reset during data bit 4 of 0xFF
      repeat (24) @(negedge clk);
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      repeat (12) @(negedge clk);
      res = 1'b1;
      @(negedge clk);
      res = 1'b0;
      check("mid_rst_data", 32'(data), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_valid", 32'(valid), 32'd0);
      check("mid_rst_ferr", 32'(frame_err), 32'd0);
      last_good = 8'h00;
      repeat (12 + 3 * 24 + 24) @(negedge clk);
      compare_events("abort");
      send_frame(8'h55, 1'b1);
      compare_events("after_rst");
      check("after_rst_data", 32'(data), 32'h55);

      // Randomised frames with occasional framing errors and random gaps
      for (int f = 0; f < 16; f++) begin
         d    = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 7) != 0);
         send_frame(d, stop);
         if (!stop) begin
            repeat ($urandom_range(10, 60)) @(negedge clk);
            rx = 1'b1;
            repeat (24 + $urandom_range(0, 20)) @(negedge clk);
         end else begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
         end
      end
      compare_events("rand");
      check("rand_data", 32'(data), 32'(last_good));

      // uart_clk frozen: rx activity must be ignored
      uc_run = 1'b0;
      repeat (8) @(negedge clk);
      busy_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         if (i % 5 == 0) rx = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (busy || valid || frame_err) busy_cnt++;
      end
      check("frozen_activity", 32'(busy_cnt), 32'd0);
      rx = 1'b1;
      repeat (10) @(negedge clk);
      uc_run = 1'b1;
      compare_events("frozen");
      repeat (30) @(negedge clk);
      send_frame(8'hC3, 1'b1);
      compare_events("resume");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
      $fatal(1);
   end

endmodule
